// File: rtl/ym_sched_pkg.sv
// rtl/ym_sched_pkg.sv - shared defaults, prescaler encodings and state types for the slot scheduler
package ym_sched_pkg;

  localparam int SLOT_COUNT_DEF = 24;
  localparam int BUSY_SLOTS_DEF = 32;
  localparam logic [2:0] P_RESET = 3'd6;

  typedef enum logic [1:0] {
    PRESC_DIV6     = 2'd0,
    PRESC_DIV4     = 2'd1,
    PRESC_DIV2     = 2'd2,
    PRESC_DIV6_ALT = 2'd3
  } presc_e;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_PEND,
    WR_HOLD
  } wr_state_e;

  function automatic logic [2:0] presc_to_p(input logic [1:0] sel);
    case (presc_e'(sel))
      PRESC_DIV4: return 3'd4;
      PRESC_DIV2: return 3'd2;
      default:    return 3'd6;
    endcase
  endfunction

endpackage

// File: rtl/ym_slot_sched_if.sv
// rtl/ym_slot_sched_if.sv - CPU write request and register-file commit bus
interface ym_slot_sched_if;
  logic       wr_req;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic       busy;
  logic       reg_we;
  logic [7:0] reg_addr;
  logic [7:0] reg_data;

  modport master (
    output wr_req, wr_addr, wr_data,
    input  wr_ack, busy, reg_we, reg_addr, reg_data
  );

  modport slave (
    input  wr_req, wr_addr, wr_data,
    output wr_ack, busy, reg_we, reg_addr, reg_data
  );
endinterface

// File: rtl/ym_sched_div.sv
// rtl/ym_sched_div.sv - phase divider producing non-overlapping c1/c2 enables from MCLK
module ym_sched_div
  import ym_sched_pkg::*;
(
  input  logic       i_mclk,
  input  logic       i_rst_n,
  input  logic [1:0] i_presc,
  output logic       o_c1,
  output logic       o_c2,
  output logic       o_c1_set
);

  logic [2:0] r_phase;
  logic [2:0] r_p;
  logic [2:0] w_p;
  logic       w_c2_set;

  // The period length is only re-read while the counter sits at phase 0, so a
  // running period always completes with the length it started with.
  assign w_p      = (r_phase == 3'd0) ? presc_to_p(i_presc) : r_p;
  assign o_c1_set = (r_phase == w_p - 3'd1);
  assign w_c2_set = (r_phase == (w_p >> 1) - 3'd1);

  always_ff @(posedge i_mclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase <= 3'd0;
      r_p     <= P_RESET;
      o_c1    <= 1'b0;
      o_c2    <= 1'b0;
    end else begin
      r_p     <= w_p;
      r_phase <= o_c1_set ? 3'd0 : r_phase + 3'd1;
      o_c1    <= o_c1_set;
      o_c2    <= w_c2_set;
    end
  end

endmodule

// File: rtl/ym_slot_sched.sv
// rtl/ym_slot_sched.sv - slot sequencer and single-entry register write arbiter
module ym_slot_sched
  import ym_sched_pkg::*;
#(
  parameter int SLOT_COUNT = SLOT_COUNT_DEF,
  parameter int BUSY_SLOTS = BUSY_SLOTS_DEF
) (
  input  logic                  MCLK,
  input  logic                  reset_n,
  input  logic [1:0]            presc,
  ym_slot_sched_if.slave        wr,
  output logic                  c1,
  output logic                  c2,
  output logic [4:0]            slot,
  output logic                  cycle_sync
);

  localparam int CW = $clog2(BUSY_SLOTS) + 1;

  logic            w_c1_set;
  logic [4:0]      w_slot_next;
  wr_state_e       r_state;
  logic [CW-1:0]   r_cnt;

  ym_sched_div u_div (
    .i_mclk   (MCLK),
    .i_rst_n  (reset_n),
    .i_presc  (presc),
    .o_c1     (c1),
    .o_c2     (c2),
    .o_c1_set (w_c1_set)
  );

  always_comb begin
    w_slot_next = slot;
    if (c2)
      w_slot_next = (slot == 5'(SLOT_COUNT - 1)) ? 5'd0 : slot + 5'd1;
  end

  // cycle_sync looks at the slot value being loaded on the same edge as c1.
  always_ff @(posedge MCLK or negedge reset_n) begin
    if (!reset_n) begin
      slot       <= 5'd0;
      cycle_sync <= 1'b0;
    end else begin
      slot       <= w_slot_next;
      cycle_sync <= w_c1_set && (w_slot_next == 5'd0);
    end
  end

  always_ff @(posedge MCLK or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= WR_IDLE;
      r_cnt       <= '0;
      wr.wr_ack   <= 1'b0;
      wr.busy     <= 1'b0;
      wr.reg_we   <= 1'b0;
      wr.reg_addr <= 8'd0;
      wr.reg_data <= 8'd0;
    end else begin
      wr.wr_ack <= 1'b0;
      wr.reg_we <= 1'b0;
      case (r_state)
        WR_IDLE: begin
          if (wr.wr_req) begin
            wr.reg_addr <= wr.wr_addr;
            wr.reg_data <= wr.wr_data;
            wr.wr_ack   <= 1'b1;
            wr.busy     <= 1'b1;
            r_state     <= WR_PEND;
          end
        end
        // Entered on the accept edge, so a c1 coinciding with wr_ack is skipped.
        WR_PEND: begin
          if (w_c1_set) begin
            wr.reg_we <= 1'b1;
            r_cnt     <= '0;
            r_state   <= WR_HOLD;
          end
        end
        WR_HOLD: begin
          if (c2) begin
            if (r_cnt == CW'(BUSY_SLOTS - 1)) begin
              wr.busy <= 1'b0;
              r_state <= WR_IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= WR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ym_slot_sched.sv
// tb/tb_ym_slot_sched.sv - self-checking bench for ym_slot_sched
module tb_ym_slot_sched;

  logic       MCLK = 1'b0;
  logic       reset_n = 1'b1;
  logic [1:0] presc = 2'd0;
  logic       c1, c2, cycle_sync;
  logic [4:0] slot;

  ym_slot_sched_if wr_if ();

  ym_slot_sched dut (
    .MCLK       (MCLK),
    .reset_n    (reset_n),
    .presc      (presc),
    .wr         (wr_if.slave),
    .c1         (c1),
    .c2         (c2),
    .slot       (slot),
    .cycle_sync (cycle_sync)
  );

  always #5 MCLK = ~MCLK;

  int edge_cnt = 0;
  always @(posedge MCLK or negedge reset_n) begin
    if (!reset_n) edge_cnt = 0;
    else          edge_cnt++;
  end

  int          n_checks = 0;
  int          n_pass = 0;
  int          q_c1[$];
  int          q_c2[$];
  logic [15:0] q_wr[$];

  task automatic do_reset(input logic [1:0] p);
    @(negedge MCLK);
    reset_n = 1'b0;
    wr_if.wr_req = 1'b0;
    repeat (2) @(negedge MCLK);
    presc = p;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [26:0] got;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge MCLK);
    got = {c1, c2, slot, cycle_sync, wr_if.wr_ack, wr_if.busy, wr_if.reg_we,
           wr_if.reg_addr, wr_if.reg_data};
    n_checks++;
    if (got !== 27'd0) $display("FAIL reset_outputs got=%h exp=0", got);
    else n_pass++;
  endtask

  task automatic test_timing();
    int exp_e;
    logic overlap = 1'b0;
    do_reset(2'd0);
    q_c1 = {6, 12, 18};
    q_c2 = {3, 9, 15};
    for (int i = 0; i < 20; i++) begin
      @(negedge MCLK);
      if (c1 && c2) overlap = 1'b1;
      if (c1) begin
        exp_e = (q_c1.size() != 0) ? q_c1.pop_front() : -1;
        n_checks++;
        if (edge_cnt !== exp_e) $display("FAIL timing_c1 edge=%0d exp=%0d", edge_cnt, exp_e);
        else n_pass++;
      end
      if (c2) begin
        exp_e = (q_c2.size() != 0) ? q_c2.pop_front() : -1;
        n_checks++;
        if (edge_cnt !== exp_e) $display("FAIL timing_c2 edge=%0d exp=%0d", edge_cnt, exp_e);
        else n_pass++;
      end
      if (edge_cnt == 3 || edge_cnt == 4) begin
        n_checks++;
        if (slot !== ((edge_cnt == 4) ? 5'd1 : 5'd0))
          $display("FAIL timing_slot edge=%0d got=%0d", edge_cnt, slot);
        else n_pass++;
      end
    end
    n_checks++;
    if ((q_c1.size() + q_c2.size()) !== 0 || overlap !== 1'b0)
      $display("FAIL timing_missing left=%0d overlap=%b exp 0/0", q_c1.size() + q_c2.size(), overlap);
    else n_pass++;
  endtask

  task automatic test_slot_wrap();
    logic [7:0] got, exp;
    int exp_slot;
    int wraps = 0;
    logic [4:0] prev_slot = 5'd0;
    do_reset(2'd2);
    for (int i = 0; i < 96; i++) begin
      @(negedge MCLK);
      exp_slot = (edge_cnt / 2) % 24;
      exp = {edge_cnt[0] == 1'b0, edge_cnt[0] == 1'b1, 5'(exp_slot),
             (edge_cnt[0] == 1'b0) && (exp_slot == 0)};
      got = {c1, c2, slot, cycle_sync};
      n_checks++;
      if (got !== exp) $display("FAIL slot_wrap edge=%0d got=%h exp=%h", edge_cnt, got, exp);
      else n_pass++;
      if (prev_slot == 5'd23 && slot == 5'd0) wraps++;
      prev_slot = slot;
    end
    n_checks++;
    if (wraps !== 2) $display("FAIL slot_wrap_count got=%0d exp=2", wraps);
    else n_pass++;
  endtask

  task automatic test_write();
    logic [15:0] exp;
    int lat = 0;
    logic seen = 1'b0;
    for (int i = 0; i < 4 && !c1; i++) @(negedge MCLK);
    wr_if.wr_req = 1'b1; wr_if.wr_addr = 8'h28; wr_if.wr_data = 8'hF0;
    q_wr.push_back(16'h28F0);
    @(negedge MCLK);
    n_checks++;
    if ({wr_if.wr_ack, wr_if.busy, wr_if.reg_addr, wr_if.reg_data} !== {2'b11, 16'h28F0})
      $display("FAIL write_accept got=%b%b %h%h exp=11 28f0", wr_if.wr_ack, wr_if.busy,
               wr_if.reg_addr, wr_if.reg_data);
    else n_pass++;
    wr_if.wr_req = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge MCLK);
      lat++;
      if (wr_if.reg_we) begin
        seen = 1'b1;
        exp = (q_wr.size() != 0) ? q_wr.pop_front() : 16'hxxxx;
        n_checks++;
        if ({c1, wr_if.wr_ack, wr_if.reg_addr, wr_if.reg_data} !== {2'b10, exp} || lat !== 1)
          $display("FAIL write_commit c1=%b ack=%b reg=%h%h lat=%0d exp c1=1 ack=0 reg=%h lat=1",
                   c1, wr_if.wr_ack, wr_if.reg_addr, wr_if.reg_data, lat, exp);
        else n_pass++;
      end
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL write_commit_timeout got=no reg_we exp=reg_we");
    end
  endtask

  task automatic test_busy_hold();
    logic [15:0] exp;
    int n_c2 = 0;
    logic prev_c2 = 1'b0;
    logic bad = 1'b0;
    logic cleared = 1'b0;
    logic seen = 1'b0;
    wr_if.wr_req = 1'b1; wr_if.wr_addr = 8'h30; wr_if.wr_data = 8'h55;
    q_wr.push_back(16'h3055);
    for (int i = 0; i < 200 && !cleared; i++) begin
      @(negedge MCLK);
      if (wr_if.wr_ack || wr_if.reg_addr != 8'h28 || wr_if.reg_data != 8'hF0) bad = 1'b1;
      if (!wr_if.busy) cleared = 1'b1;
      else begin
        if (c2) n_c2++;
        prev_c2 = c2;
      end
    end
    n_checks++;
    if ({cleared, bad, prev_c2} !== 3'b101 || n_c2 !== 32)
      $display("FAIL busy_hold cleared=%b ignored_bad=%b last_c2=%b c2s=%0d exp 1/0/1/32",
               cleared, bad, prev_c2, n_c2);
    else n_pass++;
    @(negedge MCLK);
    n_checks++;
    if ({wr_if.wr_ack, wr_if.busy, wr_if.reg_addr, wr_if.reg_data} !== {2'b11, 16'h3055})
      $display("FAIL busy_held_accept got=%b%b %h%h exp=11 3055", wr_if.wr_ack, wr_if.busy,
               wr_if.reg_addr, wr_if.reg_data);
    else n_pass++;
    wr_if.wr_req = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge MCLK);
      if (wr_if.reg_we) begin
        seen = 1'b1;
        exp = (q_wr.size() != 0) ? q_wr.pop_front() : 16'hxxxx;
        n_checks++;
        if ({wr_if.reg_addr, wr_if.reg_data} !== exp)
          $display("FAIL busy_held_commit got=%h%h exp=%h", wr_if.reg_addr, wr_if.reg_data, exp);
        else n_pass++;
      end
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL busy_held_timeout got=no reg_we exp=reg_we");
    end
  endtask

  task automatic test_ack_c1_same();
    logic [15:0] exp;
    int lat = 0;
    logic seen = 1'b0;
    for (int i = 0; i < 200 && wr_if.busy; i++) @(negedge MCLK);
    for (int i = 0; i < 4 && !c2; i++) @(negedge MCLK);
    wr_if.wr_req = 1'b1; wr_if.wr_addr = 8'h11; wr_if.wr_data = 8'h22;
    q_wr.push_back(16'h1122);
    @(negedge MCLK);
    n_checks++;
    if ({wr_if.wr_ack, c1, wr_if.reg_we} !== 3'b110)
      $display("FAIL ack_c1_same got ack/c1/we=%b%b%b exp=110", wr_if.wr_ack, c1, wr_if.reg_we);
    else n_pass++;
    wr_if.wr_req = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge MCLK);
      lat++;
      if (wr_if.reg_we) begin
        seen = 1'b1;
        exp = (q_wr.size() != 0) ? q_wr.pop_front() : 16'hxxxx;
        n_checks++;
        if ({c1, wr_if.reg_addr, wr_if.reg_data} !== {1'b1, exp} || lat !== 2)
          $display("FAIL ack_c1_commit c1=%b reg=%h%h lat=%0d exp c1=1 reg=%h lat=2",
                   c1, wr_if.reg_addr, wr_if.reg_data, lat, exp);
        else n_pass++;
      end
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL ack_c1_timeout got=no reg_we exp=reg_we");
    end
  endtask

  task automatic test_presc_change();
    int exp_e;
    do_reset(2'd0);
    q_c1 = {6, 12, 16, 20, 24};
    q_c2 = {3, 9, 14, 18, 22};
    for (int i = 0; i < 25; i++) begin
      @(negedge MCLK);
      if (c1) begin
        exp_e = (q_c1.size() != 0) ? q_c1.pop_front() : -1;
        n_checks++;
        if (edge_cnt !== exp_e) $display("FAIL presc_c1 edge=%0d exp=%0d", edge_cnt, exp_e);
        else n_pass++;
      end
      if (c2) begin
        exp_e = (q_c2.size() != 0) ? q_c2.pop_front() : -1;
        n_checks++;
        if (edge_cnt !== exp_e) $display("FAIL presc_c2 edge=%0d exp=%0d", edge_cnt, exp_e);
        else n_pass++;
      end
      if (edge_cnt == 8) presc = 2'd1;
    end
    n_checks++;
    if ((q_c1.size() + q_c2.size()) !== 0)
      $display("FAIL presc_missing left=%0d exp=0", q_c1.size() + q_c2.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid_write();
    logic [26:0] got;
    logic late = 1'b0;
    do_reset(2'd0);
    @(negedge MCLK);
    wr_if.wr_req = 1'b1; wr_if.wr_addr = 8'h77; wr_if.wr_data = 8'h99;
    @(negedge MCLK);
    n_checks++;
    if (wr_if.wr_ack !== 1'b1) $display("FAIL midrst_ack got=%b exp=1", wr_if.wr_ack);
    else n_pass++;
    wr_if.wr_req = 1'b0;
    @(negedge MCLK);
    reset_n = 1'b0;
    #1;
    got = {c1, c2, slot, cycle_sync, wr_if.wr_ack, wr_if.busy, wr_if.reg_we,
           wr_if.reg_addr, wr_if.reg_data};
    n_checks++;
    if (got !== 27'd0) $display("FAIL midrst_outputs got=%h exp=0", got);
    else n_pass++;
    repeat (2) @(negedge MCLK);
    reset_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge MCLK);
      if (wr_if.reg_we || wr_if.wr_ack || wr_if.busy) late = 1'b1;
    end
    n_checks++;
    if (late !== 1'b0) $display("FAIL midrst_late_commit got=%b exp=0", late);
    else n_pass++;
  endtask

  initial begin
    wr_if.wr_req = 1'b0;
    wr_if.wr_addr = 8'h00;
    wr_if.wr_data = 8'h00;
    test_reset();
    test_timing();
    test_slot_wrap();
    test_write();
    test_busy_hold();
    test_ack_c1_same();
    test_presc_change();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/ym_slot_sched.md
YM_SLOT_SCHED -- requirements
Module: ym_slot_sched

Interface
REQ-001 SHALL have parameter SLOT_COUNT, default 24, meaning slots per sample cycle.
REQ-002 SHALL have parameter BUSY_SLOTS, default 32, meaning c2 pulses that busy is held after a register commit.
REQ-003 SHALL have port MCLK  in  1  master clock; all state on its rising edge.
REQ-004 SHALL have port reset_n  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have port presc  in  2  divider select: 0 → P=6, 1 → P=4, 2 → P=2, 3 → P=6.
REQ-006 SHALL have port wr_req  in  1  CPU register-write request, level.
REQ-007 SHALL have port wr_addr  in  8  write address.
REQ-008 SHALL have port wr_data  in  8  write data.
REQ-009 SHALL have port c1  out  1  phase-1 enable, one MCLK wide.
REQ-010 SHALL have port c2  out  1  phase-2 enable, one MCLK wide.
REQ-011 SHALL have port slot  out  5  current slot index, 0..SLOT_COUNT-1.
REQ-012 SHALL have port cycle_sync  out  1  high with the c1 pulse of slot 0.
REQ-013 SHALL have port wr_ack  out  1  one-MCLK pulse: write accepted.
REQ-014 SHALL have port busy  out  1  write path occupied.
REQ-015 SHALL have port reg_we  out  1  commit strobe to register file.
REQ-016 SHALL have port reg_addr  out  8  latched address.
REQ-017 SHALL have port reg_data  out  8  latched data.

Function
REQ-018 SHALL run a phase counter 0..P-1 advancing every MCLK; count rising edges after reset release as 1, 2, 3, ....
REQ-019 SHALL drive c1 high for exactly the MCLK cycle following edges P, 2P, 3P, ...; all outputs registered.
REQ-020 SHALL drive c2 high for exactly the MCLK cycle following edges P/2, P/2+P, ...; c1 and c2 are never high together.
REQ-021 SHALL sample presc only at phase-counter wrap, so a change never shortens or splits a period.
REQ-022 SHALL increment slot on the edge that ends a c2-high cycle and wrap SLOT_COUNT-1 → 0.
REQ-023 SHALL assert cycle_sync exactly when c1 is high and slot==0.
REQ-024 SHALL accept a write on an edge where wr_req==1 and busy==0, latching wr_addr/wr_data into reg_addr/reg_data; on the same edge wr_ack goes high for 1 cycle and busy goes high.
REQ-025 SHALL ignore wr_req while busy==1: no ack, and reg_addr/reg_data stay unchanged.
REQ-026 SHALL pulse reg_we coincident with the first c1 strictly after wr_ack; if wr_ack and c1 fall in the same cycle, reg_we goes with the next c1.
REQ-027 SHALL keep busy high after reg_we until BUSY_SLOTS c2 pulses have ended; busy clears on the edge ending the BUSY_SLOTS-th c2.
REQ-028 SHALL allow wr_req in the first cycle with busy==0 to be accepted; back-to-back writes need no idle cycle.
REQ-029 SHALL hold reg_addr/reg_data stable from wr_ack until the next accepted write.

Reset
REQ-030 SHALL, while reset_n==0, force phase=0, c1=c2=0, slot=0, cycle_sync=0, wr_ack=0, busy=0, reg_we=0, reg_addr=reg_data=0, P=6.
REQ-031 SHALL discard a pending (acked, uncommitted) write on reset mid-operation; no reg_we after release.
REQ-032 SHALL sample presc on the first edge after release.

Structure
REQ-033 SHALL place SLOT_COUNT/BUSY_SLOTS defaults, presc encodings and the presc→P mapping in shared package ym_sched_pkg.
REQ-034 SHALL implement the phase divider (phase counter, c1/c2 generation, presc sampling) as sub-module ym_sched_div; slot counter and write arbiter stay in the top.

Verification
REQ-035 SHALL cover: presc=0, release reset → c1 after edges 6, 12, 18; c2 after 3, 9, 15; slot 0→1 at edge 4.
REQ-036 SHALL cover: presc=2, run 48 c2 pulses → slot wraps 23→0 twice; cycle_sync exactly with c1 at slot 0.
REQ-037 SHALL cover: wr_req with addr 0x28, data 0xF0 → wr_ack 1 cycle, reg_we at next c1 with reg_addr=0x28, reg_data=0xF0, busy clears after 32 c2 pulses.
REQ-038 SHALL cover: second wr_req (0x30/0x55) while busy → no ack, reg_addr stays 0x28; held request is accepted on first busy==0 cycle.
REQ-039 SHALL cover: presc 0→1 mid-period → current 6-cycle period completes, then 4-cycle periods.
REQ-040 SHALL cover: reset_n low between wr_ack and reg_we → all outputs 0, no reg_we after release.
